// File: rtl/sccb_arbiter_if.sv
// Requester-side and SCCB-master-side signals of sccb_arbiter.
// master: the arbiter's view of the bundle; slave: requesters plus the SCCB master.
interface sccb_arbiter_if;
  logic [2:0]  req_valid;
  logic [23:0] req_addr;
  logic [23:0] req_data;
  logic [2:0]  req_ack;
  logic [2:0]  req_done;
  logic        xfer_err;
  logic        busy;
  logic [1:0]  grant_id;
  logic        sccb_ready;
  logic        sccb_start;
  logic [7:0]  sccb_addr;
  logic [7:0]  sccb_data;

  modport master (
    input  req_valid, req_addr, req_data, sccb_ready,
    output req_ack, req_done, xfer_err, busy, grant_id,
           sccb_start, sccb_addr, sccb_data
  );

  modport slave (
    output req_valid, req_addr, req_data, sccb_ready,
    input  req_ack, req_done, xfer_err, busy, grant_id,
           sccb_start, sccb_addr, sccb_data
  );
endinterface

// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB master between three register-write requesters,
// with ready-handshake tracking, ack/transfer timeouts and a post-transaction bus-idle gap.
module sccb_arbiter #(
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter int unsigned XFER_TIMEOUT = 27000,
  parameter int unsigned GAP_CYCLES   = 270
) (
  input  logic           clk,
  input  logic           rst_n,
  sccb_arbiter_if.master bus
);

  localparam int unsigned MAX_AX = (ACK_TIMEOUT > XFER_TIMEOUT) ? ACK_TIMEOUT : XFER_TIMEOUT;
  localparam int unsigned MAX_T  = (MAX_AX > GAP_CYCLES) ? MAX_AX : GAP_CYCLES;
  localparam int unsigned TW     = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] ACK_LIMIT  = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] XFER_LIMIT = TW'(XFER_TIMEOUT);
  localparam logic [TW-1:0] GAP_LIMIT  = TW'(GAP_CYCLES);
  localparam logic [TW-1:0] TIMER_SAT  = {TW{1'b1}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, GAP} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    last_grant_q, last_grant_d;
  logic [1:0]    grant_id_q, grant_id_d;
  logic [7:0]    sccb_addr_q, sccb_addr_d;
  logic [7:0]    sccb_data_q, sccb_data_d;
  logic [2:0]    req_done_q, req_done_d;
  logic          xfer_err_q, xfer_err_d;

  logic [1:0]    pick;
  logic [TW-1:0] timer_inc;
  logic          exit_ok, exit_err;

  // First valid requester searching upward from last+1, wrapping mod 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] valid, input logic [1:0] last);
    logic [1:0] order [3];
    logic [1:0] sel;
    case (last)
      2'd0:    order = '{2'd1, 2'd2, 2'd0};
      2'd1:    order = '{2'd2, 2'd0, 2'd1};
      default: order = '{2'd0, 2'd1, 2'd2};
    endcase
    sel = order[2];
    for (int k = 2; k >= 0; k--) begin
      if (valid[order[k]]) sel = order[k];
    end
    return sel;
  endfunction

  // NOTE: the reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      last_grant_q <= 2'd2;
      grant_id_q   <= 2'd0;
      sccb_addr_q  <= 8'h00;
      sccb_data_q  <= 8'h00;
      req_done_q   <= 3'b000;
      xfer_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q      <= state_d;
      timer_q      <= timer_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      sccb_addr_q  <= sccb_addr_d;
      sccb_data_q  <= sccb_data_d;
      req_done_q   <= req_done_d;
      xfer_err_q   <= xfer_err_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    timer_d      = timer_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    sccb_addr_d  = sccb_addr_q;
    sccb_data_d  = sccb_data_q;
    req_done_d   = 3'b000;
    xfer_err_d   = 1'b0;
    exit_ok      = 1'b0;
    exit_err     = 1'b0;
    pick         = rr_pick(bus.req_valid, last_grant_q);
    timer_inc    = (timer_q == TIMER_SAT) ? timer_q : timer_q + TW'(1);

    case (state_q)
      IDLE: begin
        // A low ready here means a write is still in flight (e.g. across a reset).
        if (bus.sccb_ready && (bus.req_valid != 3'b000)) begin
          sccb_addr_d  = bus.req_addr[8*pick +: 8];
          sccb_data_d  = bus.req_data[8*pick +: 8];
          grant_id_d   = pick;
          last_grant_d = pick;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_LOW;
        timer_d = '0;
      end
      WAIT_LOW: begin
        if (!bus.sccb_ready) begin
          state_d = WAIT_HIGH;
          timer_d = '0;
        end else if (timer_q == ACK_LIMIT) begin
          exit_err = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      WAIT_HIGH: begin
        if (bus.sccb_ready) begin
          exit_ok = 1'b1;
        end else if (timer_q == XFER_LIMIT) begin
          exit_err = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      GAP: begin
        if (timer_q == GAP_LIMIT) state_d = IDLE;
        else                      timer_d = timer_inc;
      end
      default: state_d = IDLE;
    endcase

    if (exit_ok || exit_err) begin
      req_done_d = 3'b001 << grant_id_q;
      xfer_err_d = exit_err;
      state_d    = (GAP_CYCLES == 0) ? IDLE : GAP;
      timer_d    = '0;
    end
  end

  always_comb begin
    bus.sccb_start = (state_q == ISSUE);
    bus.req_ack    = (state_q == ISSUE) ? (3'b001 << grant_id_q) : 3'b000;
    bus.busy       = (state_q != IDLE);
    bus.grant_id   = grant_id_q;
    bus.sccb_addr  = sccb_addr_q;
    bus.sccb_data  = sccb_data_q;
    bus.req_done   = req_done_q;
    bus.xfer_err   = xfer_err_q;
  end

endmodule
